// File: rtl/reset_sequencer.sv
// Reset sequencer: qualifies PLL lock, releases memory reset, waits for
// memory init, then holds and releases the CPU reset. All outputs registered.
module reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int MEM_INIT_TIMEOUT   = 65536,
    parameter int RESET_HOLD_CYCLES  = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pll_locked,
    input  logic mem_init_done,
    input  logic sw_reset,
    input  logic flag_clear,
    output logic mem_reset,
    output logic cpu_reset,
    output logic running,
    output logic lock_lost,
    output logic init_timeout
);

    localparam int MAX_AB = (LOCK_STABLE_CYCLES > MEM_INIT_TIMEOUT) ?
                            LOCK_STABLE_CYCLES : MEM_INIT_TIMEOUT;
    localparam int MAX_CNT = (MAX_AB > RESET_HOLD_CYCLES) ?
                             MAX_AB : RESET_HOLD_CYCLES;
    localparam int CNT_W = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_INIT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT      = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STABLE,
        ST_MEM_INIT,
        ST_HOLD,
        ST_RUN
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic mem_reset_q, mem_reset_d;
    logic cpu_reset_q, cpu_reset_d;
    logic running_q, running_d;
    logic lock_lost_q, lock_lost_d;
    logic init_timeout_q, init_timeout_d;

    logic locked_s;
    logic enter;
    logic lost_set;
    logic timeout_set;

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], pll_locked};
        state_d     = state_q;
        enter       = 1'b0;
        lost_set    = 1'b0;
        timeout_set = 1'b0;

        // Lock loss outranks every other transition on the same edge.
        if (state_q != ST_IDLE && !locked_s) begin
            state_d  = ST_IDLE;
            enter    = 1'b1;
            lost_set = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (locked_s) begin
                        state_d = ST_STABLE;
                        enter   = 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (cnt_q == STABLE_LAST) begin
                        state_d = ST_MEM_INIT;
                        enter   = 1'b1;
                    end
                end
                ST_MEM_INIT: begin
                    if (mem_init_done) begin
                        state_d = ST_HOLD;
                        enter   = 1'b1;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d     = ST_IDLE;
                        enter       = 1'b1;
                        timeout_set = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (sw_reset) begin
                        state_d = ST_HOLD;
                        enter   = 1'b1;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d = ST_RUN;
                        enter   = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (sw_reset) begin
                        state_d = ST_HOLD;
                        enter   = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    enter   = 1'b1;
                end
            endcase
        end

        if (enter) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        mem_reset_d = (state_d == ST_IDLE) || (state_d == ST_STABLE);
        cpu_reset_d = (state_d != ST_RUN);
        running_d   = (state_d == ST_RUN);

        lock_lost_d    = lost_set    | (lock_lost_q    & ~flag_clear);
        init_timeout_d = timeout_set | (init_timeout_q & ~flag_clear);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            sync_q         <= '0;
            mem_reset_q    <= 1'b1;
            cpu_reset_q    <= 1'b1;
            running_q      <= 1'b0;
            lock_lost_q    <= 1'b0;
            init_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sync_q         <= sync_d;
            mem_reset_q    <= mem_reset_d;
            cpu_reset_q    <= cpu_reset_d;
            running_q      <= running_d;
            lock_lost_q    <= lock_lost_d;
            init_timeout_q <= init_timeout_d;
        end
    end

    assign mem_reset    = mem_reset_q;
    assign cpu_reset    = cpu_reset_q;
    assign running      = running_q;
    assign lock_lost    = lock_lost_q;
    assign init_timeout = init_timeout_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus randomized traffic,
// checked against an elapsed-time reference model.
module tb_reset_sequencer;

    localparam int SYNC = 2;
    localparam int LSC  = 8;
    localparam int TMO  = 32;
    localparam int HLD  = 4;

    localparam int P_IDLE   = 0;
    localparam int P_STABLE = 1;
    localparam int P_MEM    = 2;
    localparam int P_HOLD   = 3;
    localparam int P_RUN    = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic pll_locked = 1'b0;
    logic mem_init_done = 1'b0;
    logic sw_reset = 1'b0;
    logic flag_clear = 1'b0;
    logic mem_reset, cpu_reset, running, lock_lost, init_timeout;

    int n_checks = 0;
    int n_fail = 0;

    int m_ph;
    int m_ent;
    int m_n;
    bit m_hist[$];
    bit m_lost;
    bit m_to;

    reset_sequencer #(
        .SYNC_STAGES(SYNC),
        .LOCK_STABLE_CYCLES(LSC),
        .MEM_INIT_TIMEOUT(TMO),
        .RESET_HOLD_CYCLES(HLD)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .pll_locked(pll_locked),
        .mem_init_done(mem_init_done),
        .sw_reset(sw_reset),
        .flag_clear(flag_clear),
        .mem_reset(mem_reset),
        .cpu_reset(cpu_reset),
        .running(running),
        .lock_lost(lock_lost),
        .init_timeout(init_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [4:0] outs();
        return {mem_reset, cpu_reset, running, lock_lost, init_timeout};
    endfunction

    function automatic logic [4:0] m_exp();
        return {m_ph <= P_STABLE, m_ph != P_RUN, m_ph == P_RUN, m_lost, m_to};
    endfunction

    task automatic model_reset();
        m_hist = {};
        for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
        m_ph = P_IDLE;
        m_ent = 0;
        m_n = 0;
        m_lost = 1'b0;
        m_to = 1'b0;
    endtask

    // Phases are tracked by entry time; a phase ends after a fixed age.
    task automatic model_edge();
        bit ls;
        bit lev;
        bit tev;
        int age;
        lev = 1'b0;
        tev = 1'b0;
        ls = m_hist.pop_front();
        m_hist.push_back(pll_locked);
        age = m_n - m_ent;
        if (m_ph != P_IDLE && !ls) begin
            m_ph = P_IDLE; m_ent = m_n; lev = 1'b1;
        end else if (m_ph == P_IDLE) begin
            if (ls) begin m_ph = P_STABLE; m_ent = m_n; end
        end else if (m_ph == P_STABLE) begin
            if (age == LSC) begin m_ph = P_MEM; m_ent = m_n; end
        end else if (m_ph == P_MEM) begin
            if (mem_init_done) begin
                m_ph = P_HOLD; m_ent = m_n;
            end else if (age == TMO) begin
                m_ph = P_IDLE; m_ent = m_n; tev = 1'b1;
            end
        end else begin
            if (sw_reset) begin
                m_ph = P_HOLD; m_ent = m_n;
            end else if (m_ph == P_HOLD && age == HLD) begin
                m_ph = P_RUN; m_ent = m_n;
            end
        end
        m_lost = lev | (m_lost & !flag_clear);
        m_to = tev | (m_to & !flag_clear);
        m_n++;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        pll_locked = 1'b0;
        mem_init_done = 1'b0;
        sw_reset = 1'b0;
        flag_clear = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic bring_to_run();
        bit ok;
        ok = 1'b0;
        pll_locked = 1'b1;
        mem_init_done = 1'b1;
        sw_reset = 1'b0;
        flag_clear = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick();
            if (running === 1'b1 && m_ph == P_RUN) ok = 1'b1;
        end
        mem_init_done = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bring_to_run: running=%b model_phase=%0d after 100 cycles",
                     running, m_ph);
        end
    endtask

    task automatic test_reset();
        logic [4:0] got;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        got = outs();
        n_checks++;
        if (got !== 5'b11000) begin
            n_fail++;
            $display("FAIL reset_values: got %b expected %b", got, 5'b11000);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int e = 0; e < 4; e++) begin
            tick();
            got = outs();
            n_checks++;
            if (got !== 5'b11000 || got !== m_exp()) begin
                n_fail++;
                $display("FAIL reset_idle e=%0d: got %b expected %b", e, got, m_exp());
            end
        end
    endtask

    task automatic test_bringup();
        logic [4:0] got;
        do_reset();
        pll_locked = 1'b1;
        for (int e = 0; e < 25; e++) begin
            mem_init_done = (e >= 15);
            tick();
            got = outs();
            n_checks++;
            if (got !== m_exp()) begin
                n_fail++;
                $display("FAIL bringup e=%0d: got %b expected %b", e, got, m_exp());
            end
            if (e == 9 || e == 10) begin
                n_checks++;
                if (mem_reset !== (e == 9)) begin
                    n_fail++;
                    $display("FAIL bringup_mem_edge e=%0d: mem_reset=%b expected %b",
                             e, mem_reset, (e == 9));
                end
            end
            if (e == 18 || e == 19) begin
                n_checks++;
                if (cpu_reset !== (e == 18) || running !== (e == 19)) begin
                    n_fail++;
                    $display("FAIL bringup_cpu_edge e=%0d: cpu=%b run=%b expected %b %b",
                             e, cpu_reset, running, (e == 18), (e == 19));
                end
            end
        end
        mem_init_done = 1'b0;
    endtask

    task automatic test_lock_glitch();
        logic [4:0] got;
        do_reset();
        for (int e = 0; e < 21; e++) begin
            pll_locked = (e != 5);
            mem_init_done = (e >= 18);
            tick();
            got = outs();
            n_checks++;
            if (got !== m_exp()) begin
                n_fail++;
                $display("FAIL glitch e=%0d: got %b expected %b", e, got, m_exp());
            end
            n_checks++;
            if (mem_reset !== (e <= 15) || lock_lost !== (e >= 7)) begin
                n_fail++;
                $display("FAIL glitch_timing e=%0d: mem=%b lost=%b expected %b %b",
                         e, mem_reset, lock_lost, (e <= 15), (e >= 7));
            end
        end
        mem_init_done = 1'b0;
    endtask

    task automatic test_lock_loss_run();
        logic [4:0] got;
        do_reset();
        bring_to_run();
        for (int e = 0; e < 8; e++) begin
            pll_locked = 1'b0;
            flag_clear = (e == 2 || e == 5);
            tick();
            got = outs();
            n_checks++;
            if (got !== m_exp()) begin
                n_fail++;
                $display("FAIL lockloss e=%0d: got %b expected %b", e, got, m_exp());
            end
            if (e == 1) begin
                n_checks++;
                if (got !== 5'b00100) begin
                    n_fail++;
                    $display("FAIL lockloss_early: got %b expected %b", got, 5'b00100);
                end
            end
            if (e >= 2 && e <= 4) begin
                n_checks++;
                if (got !== 5'b11010) begin
                    n_fail++;
                    $display("FAIL lockloss_sticky e=%0d: got %b expected %b",
                             e, got, 5'b11010);
                end
            end
            if (e == 5) begin
                n_checks++;
                if (lock_lost !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lockloss_clear: lock_lost=%b expected 0", lock_lost);
                end
            end
        end
        flag_clear = 1'b0;
    endtask

    task automatic test_init_timeout();
        logic [4:0] got;
        do_reset();
        pll_locked = 1'b1;
        for (int e = 0; e < 70; e++) begin
            mem_init_done = (e >= 60);
            tick();
            got = outs();
            n_checks++;
            if (got !== m_exp()) begin
                n_fail++;
                $display("FAIL timeout e=%0d: got %b expected %b", e, got, m_exp());
            end
            if (e == 41 || e == 42) begin
                n_checks++;
                if (mem_reset !== (e == 42) || init_timeout !== (e == 42)) begin
                    n_fail++;
                    $display("FAIL timeout_edge e=%0d: mem=%b to=%b expected %b %b",
                             e, mem_reset, init_timeout, (e == 42), (e == 42));
                end
            end
            if (e == 64) begin
                n_checks++;
                if (running !== 1'b1 || init_timeout !== 1'b1) begin
                    n_fail++;
                    $display("FAIL timeout_recover: run=%b to=%b expected 1 1",
                             running, init_timeout);
                end
            end
        end
        mem_init_done = 1'b0;
    endtask

    task automatic test_timeout_boundary();
        logic [4:0] got;
        do_reset();
        pll_locked = 1'b1;
        for (int e = 0; e < 48; e++) begin
            mem_init_done = (e == 42);
            tick();
            got = outs();
            n_checks++;
            if (got !== m_exp()) begin
                n_fail++;
                $display("FAIL boundary e=%0d: got %b expected %b", e, got, m_exp());
            end
            if (e == 42 || e == 46) begin
                n_checks++;
                if (mem_reset !== 1'b0 || init_timeout !== 1'b0 ||
                    running !== (e == 46)) begin
                    n_fail++;
                    $display("FAIL boundary_done_wins e=%0d: got %b", e, got);
                end
            end
        end
        mem_init_done = 1'b0;
    endtask

    task automatic test_soft_reset();
        logic [4:0] got;
        do_reset();
        bring_to_run();
        for (int e = 0; e < 13; e++) begin
            pll_locked = (e < 8);
            sw_reset = (e == 0 || e == 10);
            tick();
            got = outs();
            n_checks++;
            if (got !== m_exp()) begin
                n_fail++;
                $display("FAIL softreset e=%0d: got %b expected %b", e, got, m_exp());
            end
            if (e <= 4) begin
                n_checks++;
                if (cpu_reset !== (e <= 3) || mem_reset !== 1'b0) begin
                    n_fail++;
                    $display("FAIL softreset_hold e=%0d: cpu=%b mem=%b expected %b 0",
                             e, cpu_reset, mem_reset, (e <= 3));
                end
            end
            if (e == 9 || e == 10) begin
                n_checks++;
                if (mem_reset !== (e == 10) || running !== (e == 9)) begin
                    n_fail++;
                    $display("FAIL softreset_vs_loss e=%0d: mem=%b run=%b", e,
                             mem_reset, running);
                end
            end
        end
        sw_reset = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [4:0] got;
        do_reset();
        for (int e = 0; e < 10; e++) begin
            pll_locked = (e != 5);
            tick();
        end
        bring_to_run();
        n_checks++;
        if (lock_lost !== 1'b1 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL async_pre: lost=%b run=%b expected 1 1", lock_lost, running);
        end
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        got = outs();
        n_checks++;
        if (got !== 5'b11000) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected %b", got, 5'b11000);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int e = 0; e < 4; e++) begin
            tick();
            got = outs();
            n_checks++;
            if (got !== 5'b11000 || got !== m_exp()) begin
                n_fail++;
                $display("FAIL async_restart e=%0d: got %b expected %b", e, got, m_exp());
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] got;
        int done_div;
        do_reset();
        done_div = 4;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) done_div = int'($urandom_range(3, 0)) * 12;
            if ($urandom_range(599, 0) == 0) begin
                reset_n = 1'b0;
                model_reset();
                #1;
                reset_n = 1'b1;
            end
            if (pll_locked) pll_locked = ($urandom_range(59, 0) != 0);
            else pll_locked = ($urandom_range(3, 0) == 0);
            mem_init_done = (done_div != 0) &&
                            ($urandom_range(done_div, 0) == 0);
            sw_reset = ($urandom_range(29, 0) == 0);
            flag_clear = ($urandom_range(24, 0) == 0);
            tick();
            got = outs();
            n_checks++;
            if (got !== m_exp()) begin
                n_fail++;
                $display("FAIL random c=%0d: got %b expected %b", c, got, m_exp());
            end
        end
        sw_reset = 1'b0;
        flag_clear = 1'b0;
        mem_init_done = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_bringup();
        test_lock_glitch();
        test_lock_loss_run();
        test_init_timeout();
        test_timeout_boundary();
        test_soft_reset();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets the pll_locked synchronizer depth (legal values are 2 or more).
REQ-002 Parameter LOCK_STABLE_CYCLES, default 1024, sets the number of consecutive locked cycles required before memory reset release (legal values are 1 or more).
REQ-003 Parameter MEM_INIT_TIMEOUT, default 65536, sets the maximum number of cycles to wait for mem_init_done (legal values are 1 or more).
REQ-004 Parameter RESET_HOLD_CYCLES, default 16, sets the number of cycles cpu_reset is held after memory init (legal values are 1 or more).
REQ-005 clk  in  1  system clock, taken from PLL output clock 0.
REQ-006 reset_n  in  1  asynchronous, active-low block reset.
REQ-007 pll_locked  in  1  PLL lock indicator, asynchronous to clk.
REQ-008 mem_init_done  in  1  SDRAM controller init complete, synchronous to clk, level.
REQ-009 sw_reset  in  1  soft CPU reset request, synchronous, one-cycle pulse.
REQ-010 flag_clear  in  1  synchronous clear of the sticky flags.
REQ-011 mem_reset  out  1  memory-subsystem reset, active-high, registered.
REQ-012 cpu_reset  out  1  CPU/core reset, active-high, registered.
REQ-013 running  out  1  high only in state RUN, registered.
REQ-014 lock_lost  out  1  sticky flag indicating PLL lock was lost after leaving IDLE.
REQ-015 init_timeout  out  1  sticky flag indicating mem_init_done did not arrive within MEM_INIT_TIMEOUT.

Function
REQ-016 pll_locked SHALL pass through a SYNC_STAGES-flop synchronizer to produce locked_s; no other logic SHALL use pll_locked directly.
REQ-017 The FSM states SHALL be IDLE, STABLE, MEM_INIT, HOLD and RUN, with one shared cycle counter cleared on every state entry.
REQ-018 Outputs per state:
- IDLE and STABLE: mem_reset=1, cpu_reset=1.
- MEM_INIT and HOLD: mem_reset=0, cpu_reset=1.
- RUN: mem_reset=0, cpu_reset=0, running=1.
REQ-019 IDLE SHALL go to STABLE on the edge that samples locked_s=1.
REQ-020 In STABLE, the counter SHALL increment each cycle; the FSM SHALL go to MEM_INIT on the edge where counter==LOCK_STABLE_CYCLES-1.
REQ-021 mem_reset SHALL therefore fall exactly SYNC_STAGES+LOCK_STABLE_CYCLES edges after the first edge that samples pll_locked high, provided pll_locked stays high.
REQ-022 MEM_INIT SHALL go to HOLD on the edge that samples mem_init_done=1.
REQ-023 MEM_INIT timeout:
- On the edge where counter==MEM_INIT_TIMEOUT-1 with mem_init_done=0, the FSM SHALL go to IDLE and set init_timeout.
- If mem_init_done=1 on that same edge, done wins and the FSM goes to HOLD.
REQ-024 HOLD SHALL go to RUN on the edge where counter==RESET_HOLD_CYCLES-1, so cpu_reset falls RESET_HOLD_CYCLES edges after HOLD entry.
REQ-025 sw_reset=1 in HOLD or RUN SHALL enter HOLD, clear the counter and assert cpu_reset on that edge; mem_reset SHALL stay 0.
REQ-026 sw_reset in IDLE, STABLE or MEM_INIT SHALL be ignored.
REQ-027 locked_s=0 in any state other than IDLE SHALL force IDLE on that edge, assert mem_reset and cpu_reset, and set lock_lost.
REQ-028 Lock loss SHALL take priority over sw_reset, mem_init_done and all counter terminal conditions occurring on the same edge.
REQ-029 In STABLE, a single-cycle locked_s drop SHALL restart the full LOCK_STABLE_CYCLES qualification from IDLE.
REQ-030 flag_clear SHALL zero lock_lost and init_timeout on the next edge; a set event on the same edge SHALL win over flag_clear.
REQ-031 Counter width SHALL be the clog2 of the largest of the three count parameters, and the counter SHALL never wrap.

Reset
REQ-032 While reset_n=0, the block SHALL immediately (asynchronously) hold:
- state=IDLE, counter=0, synchronizer flops=0;
- mem_reset=1, cpu_reset=1, running=0, lock_lost=0, init_timeout=0.
REQ-033 reset_n asserted mid-sequence, including in RUN, SHALL abort to the reset values with no partial outputs.
REQ-034 After reset_n deasserts, the sequence SHALL restart from IDLE; the sticky flags SHALL remain 0.

Verification
Parameters for all scenarios: SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, MEM_INIT_TIMEOUT=32, RESET_HOLD_CYCLES=4.
REQ-035 Normal bring-up: pll_locked high first sampled at edge 0, mem_init_done high at edge 15 -> mem_reset falls after edge 10; cpu_reset falls after edge 19; running=1 from edge 19.
REQ-036 Lock glitch: pll_locked low for 1 cycle at edge 5 of bring-up -> mem_reset stays 1; qualification restarts; lock_lost=1.
REQ-037 Lock loss in RUN: pll_locked falls at edge j -> mem_reset=1, cpu_reset=1 and running=0 after edge j+2; lock_lost=1 until flag_clear.
REQ-038 Init timeout: mem_init_done held 0 -> 32 cycles after mem_reset falls, mem_reset=1 and init_timeout=1; then re-qualification; completes once done arrives.
REQ-039 Soft reset: sw_reset pulse in RUN -> cpu_reset=1 for 4 cycles, mem_reset stays 0; sw_reset and lock loss on the same edge -> IDLE.
REQ-040 Async reset in RUN: reset_n low mid-cycle -> mem_reset=1 and cpu_reset=1 immediately (before the next clk edge); all flags=0.
